hawkes_thinning_step: RTL and testbench
=======================================

Name: hawkes_thinning_step

Overview:
- Discrete-time Hawkes event generator; sits directly downstream of the 8-bit LFSR random source in the Monte Carlo chain.
- Each simulation step consumes one uniform byte and compares it against the current intensity to decide whether an event fires.
- After each step, intensity decays toward baseline and jumps by alpha on an event.
- Counts events over a programmed run of n_steps and reports completion.

Parameters:
- RND_W, 8, width of the uniform random input.
- LAM_W, 16, width of intensity, mu and alpha datapath (unsigned, units of 2^-RND_W events/step).
- CNT_W, 16, width of the step and event counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  begins a run; sampled only in IDLE.
- mu  in  LAM_W  baseline intensity; latched at start.
- alpha  in  LAM_W  excitation jump per event; latched at start.
- decay_shift  in  4  excess decay: excess -= excess>>decay_shift; latched at start.
- n_steps  in  CNT_W  steps per run; latched at start.
- rnd  in  RND_W  uniform random value (LFSR out).
- rnd_valid  in  1  rnd is valid this cycle (tie high for a free-running LFSR).
- rnd_ready  out  1  block consumes rnd this cycle.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- event  out  1  one-cycle pulse, event fired on the last accepted step.
- event_count  out  CNT_W  events in current/last run.
- lambda  out  LAM_W  current intensity.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (rnd_ready, busy, done, event, event_count, lambda); internal step counter and latched config 0. Reset mid-run aborts the run immediately; no done pulse is issued.
- FSM: IDLE, RUN, FIN.
  - IDLE + start: latch config, lambda<=mu, event_count<=0, step counter<=0. Next state is RUN, or FIN if n_steps==0.
  - RUN: rnd_ready=1 and busy=1.
  - Accept means rnd_valid && rnd_ready. In RUN, rnd_valid=0 is a stall: all state held, ready stays 1.
  - On the accept of step n_steps-1: next state FIN.
  - FIN: done=1 for exactly one cycle, busy=0, rnd_ready=0; then IDLE.
- Start while RUN/FIN is ignored. A start in the FIN cycle is also ignored.
- Step arithmetic on accept (registered; visible the cycle after accept):
  - Fire when zero-extended rnd < lambda. lambda >= 2^RND_W means certain fire; lambda==0 means never.
  - excess = lambda - mu (invariant lambda >= mu).
  - lambda_next = mu + (excess - (excess>>decay_shift)) + (fire ? alpha : 0). Compute one bit wide and saturate to all-ones.
  - decay_shift==0 collapses excess to 0.
  - event <= fire, a pulse lasting one cycle. event is 0 on any cycle without an accept.
  - event_count += fire, saturating at all-ones.
- Latency:
  - start at cycle k gives rnd_ready=1 at k+1.
  - Accept at cycle c gives event/lambda/event_count updated at c+1.
  - The last accept at c gives done=1 at c+1, in the same cycle as its event pulse.
  - n_steps==0: start at k gives done at k+1, with no rnd consumed.
- lambda and event_count hold their final values in IDLE until the next start or reset.
- mu/alpha/n_steps changes during RUN have no effect.

Test Plan:
- Quiet run: mu=0, alpha=0, n_steps=10, rnd_valid=1, rnd any -> exactly 10 accepts; no event pulses; lambda=0; event_count=0; done 1 cycle after 10th accept.
- Certain fire: mu=256, alpha=0, decay_shift=2, n_steps=5 -> event high on 5 consecutive cycles; event_count=5; lambda stays 256.
- Decay trace:
  - Config: mu=16, alpha=64, decay_shift=1, n_steps=3.
  - rnd sequence 10,255,255.
  - Expected: event 1,0,0; lambda 80,48,32; event_count=1.
- Stall and zero length:
  - Drop rnd_valid for 3 cycles mid-run -> lambda, event_count and step counter frozen; rnd_ready stays 1; done delayed by exactly 3 cycles.
  - Separately, n_steps=0 -> done at start+1; rnd_ready never asserted.
- Saturation and reset:
  - mu=16'hFFF0, alpha=16'h00FF, rnd=0 -> lambda=16'hFFFF after the first step.
  - Assert rst_n=0 mid-run -> all outputs 0 immediately, without waiting for a clock edge; no done pulse.
  - Release reset, then start -> clean new run.

Source files
------------

// File: rtl/hawkes_thinning_step.sv
// Discrete-time Hawkes event generator using thinning against a uniform byte.
// Each accepted random value is one simulation step: an event fires when the
// value falls below the current intensity, then the intensity decays toward
// its baseline and jumps by alpha on an event. Counts events over a run.
module hawkes_thinning_step #(
    parameter int RND_W = 8,
    parameter int LAM_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LAM_W-1:0] mu_i,
    input  logic [LAM_W-1:0] alpha_i,
    input  logic [3:0]       decay_shift_i,
    input  logic [CNT_W-1:0] n_steps_i,
    input  logic [RND_W-1:0] rnd_i,
    input  logic             rnd_valid_i,
    output logic             rnd_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             event_o,
    output logic [CNT_W-1:0] event_count_o,
    output logic [LAM_W-1:0] lambda_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LAM_W-1:0] mu_q, mu_d;
    logic [LAM_W-1:0] alpha_q, alpha_d;
    logic [3:0]       shift_q, shift_d;
    logic [CNT_W-1:0] nsteps_q, nsteps_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [LAM_W-1:0] lambda_q, lambda_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             event_q, event_d;

    logic             accept;
    logic             fire;
    logic [LAM_W-1:0] excess;
    logic [LAM_W-1:0] excessDecayed;
    logic [LAM_W:0]   lambdaSum;
    logic [LAM_W-1:0] lambdaSat;

    // Step datapath: thinning compare, excess decay and one-bit-wide sum for saturation.
    // Mu plus decayed excess never exceeds lambda, so adding alpha cannot overflow LAM_W+1 bits.
    assign accept        = (state_q == RUN) && rnd_valid_i;
    assign fire          = LAM_W'(rnd_i) < lambda_q;
    assign excess        = lambda_q - mu_q;
    assign excessDecayed = excess - (excess >> shift_q);
    assign lambdaSum     = {1'b0, mu_q} + {1'b0, excessDecayed}
                         + (fire ? {1'b0, alpha_q} : {(LAM_W+1){1'b0}});
    assign lambdaSat     = lambdaSum[LAM_W] ? {LAM_W{1'b1}} : lambdaSum[LAM_W-1:0];

    // Next-state logic: config latch on start, step update on accept, one FIN cycle for done.
    always_comb begin
        state_d  = state_q;
        mu_d     = mu_q;
        alpha_d  = alpha_q;
        shift_d  = shift_q;
        nsteps_d = nsteps_q;
        step_d   = step_q;
        lambda_d = lambda_q;
        count_d  = count_q;
        event_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mu_d     = mu_i;
                    alpha_d  = alpha_i;
                    shift_d  = decay_shift_i;
                    nsteps_d = n_steps_i;
                    step_d   = '0;
                    lambda_d = mu_i;
                    count_d  = '0;
                    state_d  = (n_steps_i == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    lambda_d = lambdaSat;
                    event_d  = fire;
                    if (fire && (count_q != {CNT_W{1'b1}})) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (step_q == nsteps_q - CNT_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        step_d = step_q + CNT_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mu_q     <= '0;
            alpha_q  <= '0;
            shift_q  <= '0;
            nsteps_q <= '0;
            step_q   <= '0;
            lambda_q <= '0;
            count_q  <= '0;
            event_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mu_q     <= mu_d;
            alpha_q  <= alpha_d;
            shift_q  <= shift_d;
            nsteps_q <= nsteps_d;
            step_q   <= step_d;
            lambda_q <= lambda_d;
            count_q  <= count_d;
            event_q  <= event_d;
        end
    end

    // Outputs decode directly from registered state so reset clears them without a clock.
    assign rnd_ready_o   = (state_q == RUN);
    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == FIN);
    assign event_o       = event_q;
    assign event_count_o = count_q;
    assign lambda_o      = lambda_q;

endmodule

// File: tb/tb_hawkes_thinning_step.sv
// Directed testbench for hawkes_thinning_step with hand-computed expectations.
module tb_hawkes_thinning_step;

    localparam int RND_W = 8;
    localparam int LAM_W = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic [LAM_W-1:0] mu_i;
    logic [LAM_W-1:0] alpha_i;
    logic [3:0]       decay_shift_i;
    logic [CNT_W-1:0] n_steps_i;
    logic [RND_W-1:0] rnd_i;
    logic             rnd_valid_i;
    logic             rnd_ready_o;
    logic             busy_o;
    logic             done_o;
    logic             event_o;
    logic [CNT_W-1:0] event_count_o;
    logic [LAM_W-1:0] lambda_o;

    int checkCount = 0;
    int failCount  = 0;

    // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    hawkes_thinning_step #(
        .RND_W(RND_W),
        .LAM_W(LAM_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mu_i         (mu_i),
        .alpha_i      (alpha_i),
        .decay_shift_i(decay_shift_i),
        .n_steps_i    (n_steps_i),
        .rnd_i        (rnd_i),
        .rnd_valid_i  (rnd_valid_i),
        .rnd_ready_o  (rnd_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .event_o      (event_o),
        .event_count_o(event_count_o),
        .lambda_o     (lambda_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle start, then scrambles the config inputs to show they were latched.
    task automatic applyStimulus(input logic [15:0] mu, input logic [15:0] alpha,
                                 input logic [3:0] sh, input logic [15:0] n);
        mu_i          = mu;
        alpha_i       = alpha;
        decay_shift_i = sh;
        n_steps_i     = n;
        start_i       = 1'b1;
        tick();
        start_i       = 1'b0;
        mu_i          = ~mu;
        alpha_i       = ~alpha;
        decay_shift_i = sh + 4'd1;
        n_steps_i     = n + 16'd3;
    endtask

    // Directed scenario sequence: reset, quiet, certain fire, decay with stall, zero length, saturation, reset abort.
    initial begin
        int accepts;
        int evs;
        int earlyDone;

        rst_n         = 1'b0;
        start_i       = 1'b0;
        mu_i          = '0;
        alpha_i       = '0;
        decay_shift_i = '0;
        n_steps_i     = '0;
        rnd_i         = '0;
        rnd_valid_i   = 1'b0;

        #2;
        checkOutput("rst_ready", rnd_ready_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_event", event_o, 0);
        checkOutput("rst_count", event_count_o, 0);
        checkOutput("rst_lambda", lambda_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Quiet run: zero intensity never fires, exactly ten accepts.
        rnd_valid_i = 1'b1;
        applyStimulus(16'd0, 16'd0, 4'd3, 16'd10);
        checkOutput("quiet_ready", rnd_ready_o, 1);
        checkOutput("quiet_busy", busy_o, 1);
        accepts = 0;
        evs = 0;
        earlyDone = 0;
        for (int i = 0; i < 10; i++) begin
            rnd_i = (i == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (rnd_ready_o && rnd_valid_i) accepts++;
            tick();
            evs += int'(event_o);
            if (i < 9 && done_o) earlyDone++;
        end
        checkOutput("quiet_accepts", accepts, 10);
        checkOutput("quiet_events", evs, 0);
        checkOutput("quiet_early_done", earlyDone, 0);
        checkOutput("quiet_done", done_o, 1);
        checkOutput("quiet_fin_busy", busy_o, 0);
        checkOutput("quiet_fin_ready", rnd_ready_o, 0);
        checkOutput("quiet_lambda", lambda_o, 0);
        checkOutput("quiet_count", event_count_o, 0);
        start_i   = 1'b1;
        mu_i      = 16'd7;
        n_steps_i = 16'd4;
        tick();
        start_i = 1'b0;
        checkOutput("fin_start_done", done_o, 0);
        checkOutput("fin_start_busy", busy_o, 0);
        tick();
        checkOutput("fin_start_ignored", busy_o, 0);

        // Certain fire: lambda 256 exceeds every byte value.
        applyStimulus(16'd256, 16'd0, 4'd2, 16'd5);
        for (int i = 0; i < 5; i++) begin
            rnd_i = 8'($urandom_range(0, 255));
            tick();
            checkOutput($sformatf("fire_event%0d", i), event_o, 1);
            checkOutput($sformatf("fire_lambda%0d", i), lambda_o, 256);
            if (i < 4) checkOutput($sformatf("fire_nodone%0d", i), done_o, 0);
        end
        checkOutput("fire_done", done_o, 1);
        checkOutput("fire_count", event_count_o, 5);
        tick();
        checkOutput("fire_done_pulse", done_o, 0);
        checkOutput("fire_count_hold", event_count_o, 5);
        checkOutput("fire_lambda_hold", lambda_o, 256);

        // Decay trace with a three-cycle stall after the first step.
        applyStimulus(16'd16, 16'd64, 4'd1, 16'd3);
        rnd_i = 8'd10;
        tick();
        checkOutput("decay_ev1", event_o, 1);
        checkOutput("decay_lam1", lambda_o, 80);
        checkOutput("decay_cnt1", event_count_o, 1);
        rnd_valid_i = 1'b0;
        rnd_i = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall_ev%0d", i), event_o, 0);
            checkOutput($sformatf("stall_lam%0d", i), lambda_o, 80);
            checkOutput($sformatf("stall_cnt%0d", i), event_count_o, 1);
            checkOutput($sformatf("stall_ready%0d", i), rnd_ready_o, 1);
            checkOutput($sformatf("stall_done%0d", i), done_o, 0);
        end
        rnd_valid_i = 1'b1;
        rnd_i = 8'd255;
        tick();
        checkOutput("decay_ev2", event_o, 0);
        checkOutput("decay_lam2", lambda_o, 48);
        checkOutput("decay_nodone2", done_o, 0);
        rnd_i = 8'd255;
        tick();
        checkOutput("decay_ev3", event_o, 0);
        checkOutput("decay_lam3", lambda_o, 32);
        checkOutput("decay_done", done_o, 1);
        checkOutput("decay_cnt", event_count_o, 1);
        tick();
        checkOutput("decay_idle_done", done_o, 0);
        checkOutput("decay_idle_lam", lambda_o, 32);
        checkOutput("decay_idle_busy", busy_o, 0);

        // Zero-length run: done right after start, no random consumed.
        applyStimulus(16'd5, 16'd9, 4'd2, 16'd0);
        checkOutput("zero_done", done_o, 1);
        checkOutput("zero_ready", rnd_ready_o, 0);
        checkOutput("zero_busy", busy_o, 0);
        checkOutput("zero_lambda", lambda_o, 5);
        checkOutput("zero_count", event_count_o, 0);
        tick();
        checkOutput("zero_done_pulse", done_o, 0);
        checkOutput("zero_ready_idle", rnd_ready_o, 0);

        // Saturation: FFF0 + FF clips to FFFF, then reset aborts the run.
        applyStimulus(16'hFFF0, 16'h00FF, 4'd3, 16'd4);
        rnd_i = 8'd0;
        tick();
        checkOutput("sat_lam1", lambda_o, 16'hFFFF);
        checkOutput("sat_ev1", event_o, 1);
        checkOutput("sat_cnt1", event_count_o, 1);
        tick();
        checkOutput("sat_lam2", lambda_o, 16'hFFFF);
        checkOutput("sat_cnt2", event_count_o, 2);
        checkOutput("sat_nodone", done_o, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", rnd_ready_o, 0);
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_done", done_o, 0);
        checkOutput("abort_event", event_o, 0);
        checkOutput("abort_count", event_count_o, 0);
        checkOutput("abort_lambda", lambda_o, 0);
        tick();
        checkOutput("abort_hold_done", done_o, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_done", done_o, 0);
        checkOutput("post_rst_busy", busy_o, 0);

        // Fresh run after reset with decay_shift 0 collapsing excess.
        applyStimulus(16'h0020, 16'h0010, 4'd0, 16'd2);
        checkOutput("new_ready", rnd_ready_o, 1);
        checkOutput("new_lambda0", lambda_o, 16'h0020);
        checkOutput("new_count0", event_count_o, 0);
        rnd_i = 8'h10;
        tick();
        checkOutput("new_ev1", event_o, 1);
        checkOutput("new_lam1", lambda_o, 16'h0030);
        rnd_i = 8'h2F;
        tick();
        checkOutput("new_ev2", event_o, 1);
        checkOutput("new_lam2", lambda_o, 16'h0030);
        checkOutput("new_cnt2", event_count_o, 2);
        checkOutput("new_done", done_o, 1);
        tick();
        checkOutput("new_done_pulse", done_o, 0);
        checkOutput("new_event_pulse", event_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
